// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port: fetch stage drives request and address, memory answers
// with rdy and read data in the same or a later cycle.
interface ifetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdy,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdy,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/rdy handshake, holds the
// instruction until retire, then selects the next PC from the jump/branch outcome.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   ifetch_unit_if.master imem,
   output logic [31:0]   o_instr,
   output logic [5:0]    o_opcode,
   output logic [5:0]    o_funct,
   output logic          o_instr_valid,
   output logic [31:0]   o_pc,
   output logic [31:0]   o_pc_plus4,
   input  logic          i_retire,
   input  logic          i_jump,
   input  logic          i_branch,
   input  logic          i_br_taken,
   output logic [31:0]   o_retired_cnt
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_cnt;
   logic        r_valid;
   logic        r_req;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_next_pc;
   logic        w_fire;
   logic        w_retire;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

   // Jump outranks a taken branch.
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (i_jump) begin
         w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      end else if (i_branch && i_br_taken) begin
         w_next_pc = w_pc_plus4 + w_br_off;
      end
   end

   assign w_fire   = (r_state == StReq) && imem.imem_rdy;
   assign w_retire = (r_state == StHold) && r_valid && i_retire;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_cnt   <= 32'd0;
         r_valid <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_state <= StReq;
               r_req   <= 1'b1;
            end
            StReq: begin
               if (w_fire) begin
                  r_instr <= imem.imem_rdata;
                  r_valid <= 1'b1;
                  r_req   <= 1'b0;
                  r_state <= StHold;
               end
            end
            StHold: begin
               if (w_retire) begin
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_cnt   <= r_cnt + 32'd1;
                  r_req   <= 1'b1;
                  r_state <= StReq;
               end
            end
            default: begin
               r_state <= StIdle;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_pc;

   assign o_instr       = r_instr;
   assign o_opcode      = r_instr[31:26];
   assign o_funct       = r_instr[5:0];
   assign o_instr_valid = r_valid;
   assign o_pc          = r_pc;
   assign o_pc_plus4    = w_pc_plus4;
   assign o_retired_cnt = r_cnt;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the MIPS core, directly upstream of the control decoder. Owns the program counter, issues word reads to instruction memory through a req/rdy handshake, and holds the fetched instruction stable in an instruction register while the decoder and datapath execute it. On retire it computes the next PC from the decoder's `jump`/`Branch` outputs and the ALU compare result, then starts the next fetch.

## Interface

- `RESET_PC`, 32'h0000_3000: PC loaded on reset; bits [1:0] must be 0
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  byte address of the fetch; equals `pc`
- `imem_rdy`  in  1  read data valid; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  instruction word, sampled when `imem_req`&`imem_rdy`
- `instr`  out  32  instruction register contents
- `opcode`  out  6  `instr[31:26]`, to decoder OpCode
- `funct`  out  6  `instr[5:0]`, to decoder funct
- `instr_valid`  out  1  `instr` holds a fetched, unretired instruction
- `pc`  out  32  address of the instruction in `instr` / being fetched
- `pc_plus4`  out  32  `pc`+4, mod 2^32
- `retire`  in  1  datapath done with current instruction; honoured only when `instr_valid`=1
- `jump`  in  1  decoder jump output
- `branch`  in  1  decoder Branch output
- `br_taken`  in  1  ALU compare result (EQL/BNE outcome)
- `retired_cnt`  out  32  count of retired instructions

## Operation

- States: IDLE, REQ, HOLD.
- IDLE: entered on reset, held exactly one cycle; `imem_req`=0; `imem_rdy` ignored. Next: REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc`, both stable until `imem_rdy`. On `imem_rdy`: `instr`<=`imem_rdata`, `instr_valid`<=1, go HOLD. `retire` ignored in REQ.
- HOLD: `imem_req`=0; `instr`, `pc` stable. On `retire`: `pc`<=next_pc, `instr_valid`<=0, `retired_cnt`+=1, go REQ. `instr` keeps old value until overwritten.
- next_pc priority: `jump` -> {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}; else `branch`&`br_taken` -> `pc_plus4` + ({{14{instr[15]}}, `instr[15:0]`, 2'b00}); else `pc_plus4`. All adds 32-bit, wrap modulo 2^32, no flag.
- `branch`=1 with `br_taken`=0 -> `pc_plus4`. `jump` and `branch` both 1 -> jump wins.
- `retired_cnt` wraps 0xFFFF_FFFF -> 0.
- `opcode`, `funct`, `pc_plus4` are combinational from registers.
- Reset values: `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `retired_cnt`=0, state IDLE.
- Reset mid-fetch (REQ, `imem_rdy` low or high in the reset cycle): response discarded, `instr` not loaded, `imem_req`=0 next cycle; memory must tolerate an abandoned request.

## Timing

- Reset deasserts at edge N: IDLE during cycle N, `imem_req`=1 from cycle N+1.
- Zero-wait memory (`imem_rdy` in same cycle as `imem_req`): `instr_valid`=1 one cycle after request asserted; k wait cycles add k cycles.
- `retire` at edge M: `pc` updated and `imem_req`=1 in cycle M+1.
- Minimum throughput: 2 cycles per instruction (REQ + HOLD) with zero-wait memory and `retire` asserted on the first HOLD cycle.
- `retire` pulse of one cycle suffices; held-high `retire` retires one instruction per HOLD entry only.
- Outputs are registered except `opcode`, `funct`, `pc_plus4`, `imem_addr` (wire of `pc`).

## Test plan

- Reset, zero-wait memory returning 32'h3408_0005 -> `imem_req`=1 one cycle after reset release, `imem_addr`=0x3000; next cycle `instr_valid`=1, `opcode`=6'h0D, `pc`=0x3000.
- Sequential: `retire` with `jump`=`branch`=0 -> next `imem_addr`=0x3004, `retired_cnt`=1; repeat to 0x3008.
- Branch at pc 0x3008, `instr`=32'h1109_FFFF: `branch`=1,`br_taken`=1 -> next fetch 0x3008; same with `br_taken`=0 -> 0x300C.
- Jump at pc 0x3010, `instr`=32'h0800_0C10 with `branch`=`br_taken`=1 also asserted -> next fetch 0x0000_3040 (jump priority).
- Wait states: `imem_rdy` delayed 3 cycles with `retire` pulsed during REQ -> `imem_req`/`imem_addr` stable 4 cycles, `retire` ignored, `retired_cnt` unchanged, `instr` loaded only on rdy.
- Reset while in REQ with `imem_rdy`=1 same cycle -> `instr`=0, `instr_valid`=0, `pc`=0x3000, `retired_cnt`=0, one IDLE cycle, then fetch 0x3000 again.
